sort_sequencer: RTL and testbench
=================================

SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: sort request, sampled only in IDLE.
REQ-004 SHALL have port dataIn, input, 16 bits: four 4-bit elements, e0=[3:0], e1=[7:4], e2=[11:8], e3=[15:12].
REQ-005 SHALL have port dataOut, output, 16 bits: element registers, same packing as dataIn.
REQ-006 SHALL have port busy, output, 1 bit: high in LOAD-to-SORT span (SORT state).
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port swapCount, output, 3 bits: swaps performed in current/last sort.

Function
REQ-009 SHALL implement FSM states IDLE, SORT, DONE.
REQ-010 IDLE with start=1 at an edge SHALL load dataIn into element registers, clear swapCount, set pass=0, idx=0, and go to SORT.
REQ-011 SORT SHALL perform one compare-and-swap per cycle on pair (e[idx], e[idx+1]) through a single shared 4-bit swap unit.
REQ-012 A swap SHALL occur only when e[idx] > e[idx+1] (unsigned); equal values are never swapped.
REQ-013 Each swap SHALL increment swapCount by 1; max value is 6, with no wrap.
REQ-014 The pass length SHALL be 3-pass compares (idx 0..2-pass); at the last idx of a pass, pass SHALL increment and idx SHALL reset to 0.
REQ-015 After the single compare of pass 2, the FSM SHALL go to DONE.
REQ-016 Full sort SHALL take 6 SORT cycles.
REQ-017 With start sampled at edge k, done SHALL be high in the 7th cycle after edge k.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 dataOut SHALL be final and ascending (e0 smallest) while done=1.
REQ-020 dataOut and swapCount SHALL hold their values in IDLE until the next accepted start.
REQ-021 start SHALL be ignored in SORT and DONE; no queuing.
REQ-022 busy SHALL be 1 exactly in SORT; done SHALL be 1 exactly in DONE.

Reset
REQ-023 nReset=0 SHALL immediately force IDLE, dataOut=0, swapCount=0, busy=0, done=0, pass=0, idx=0, regardless of clock.
REQ-024 Reset during SORT SHALL abort the sort, and no done pulse SHALL follow.
REQ-025 After release, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-026 Macro SORT_SEQUENCER_EARLY_EXIT_EN SHALL control early termination.
REQ-027 With the macro defined, a pass completing with zero swaps in that pass SHALL go directly to DONE; an already-sorted input SHALL give done in the 4th cycle after the start edge.
REQ-028 Without the macro, all 6 SORT cycles SHALL always execute and the REQ-017 latency SHALL be fixed.
REQ-029 The macro SHALL NOT change final dataOut or swapCount for any input.

Verification
REQ-030 Reversed input: dataIn=16'h1234, start pulse -> done in cycle 7, dataOut=16'h4321, swapCount=6.
REQ-031 Sorted input: dataIn=16'h4321 -> dataOut=16'h4321, swapCount=0, done in cycle 4 with macro and cycle 7 without.
REQ-032 Duplicates: dataIn=16'h5A5A -> dataOut=16'hAA55, swapCount=3.
REQ-033 Busy collision: dataIn=16'h1234, then start=1 with dataIn=16'hFFFF during SORT -> second request ignored, dataOut=16'h4321, exactly one done pulse.
REQ-034 Reset mid-sort: dataIn=16'h1234, nReset=0 in cycle 3 -> dataOut=0, swapCount=0, busy=0 immediately, no done; a subsequent start sorts correctly.

Source files
------------

// File: rtl/sort_sequencer.sv
// sort_sequencer: in-place bubble sort of four unsigned 4-bit elements.
// One compare-and-swap per cycle on the pair (e[idx], e[idx+1]) through a
// single shared swap unit. Passes shrink from 3 compares to 1 compare.
// Optional feature macro: SORT_SEQUENCER_EARLY_EXIT_EN. When it is defined,
// a pass that completes without swapping ends the sort early.
module sort_sequencer (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic [2:0]  swapCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_elem [4];
  logic [1:0] r_pass;
  logic [1:0] r_idx;
  logic       r_pass_swap;   // a swap already happened earlier in this pass
  logic [2:0] r_swap_cnt;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_idx_next;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_do_swap;
  logic [3:0] w_lo;
  logic [3:0] w_hi;
  logic       w_last_idx;
  logic       w_last_pass;
  logic       w_finish;

  // Shared swap unit: select the active pair and order it.
  assign w_idx_next = r_idx + 2'd1;
  assign w_a        = r_elem[r_idx];
  assign w_b        = r_elem[w_idx_next];
  assign w_do_swap  = (w_a > w_b);
  assign w_lo       = w_do_swap ? w_b : w_a;
  assign w_hi       = w_do_swap ? w_a : w_b;

  // Pass bookkeeping: pass p covers idx 0 .. 2-p.
  assign w_last_idx  = (r_idx == (2'd2 - r_pass));
  assign w_last_pass = (r_pass == 2'd2);

`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
  // A whole pass without a swap means the elements are already ordered.
  assign w_finish = w_last_idx && (w_last_pass || !(r_pass_swap || w_do_swap));
`else
  assign w_finish = w_last_idx && w_last_pass;
`endif

  // Element registers drive the output bus with the same packing as dataIn.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pack
      assign dataOut[4*gi +: 4] = r_elem[gi];
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign swapCount = r_swap_cnt;

  // Sequencer FSM with registered busy/done flags and the element datapath.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_elem[i] <= 4'd0;
      end
      r_pass      <= 2'd0;
      r_idx       <= 2'd0;
      r_pass_swap <= 1'b0;
      r_swap_cnt  <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < 4; i++) begin
              r_elem[i] <= dataIn[4*i +: 4];
            end
            r_swap_cnt  <= 3'd0;
            r_pass      <= 2'd0;
            r_idx       <= 2'd0;
            r_pass_swap <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SORT;
          end
        end

        ST_SORT: begin
          // Writing back the ordered pair is a no-op when no swap is needed.
          r_elem[r_idx]      <= w_lo;
          r_elem[w_idx_next] <= w_hi;
          if (w_do_swap && (r_swap_cnt != 3'd6)) begin
            r_swap_cnt <= r_swap_cnt + 3'd1;
          end
          if (w_finish) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_last_idx) begin
            r_pass      <= r_pass + 2'd1;
            r_idx       <= 2'd0;
            r_pass_swap <= 1'b0;
          end else begin
            r_idx       <= w_idx_next;
            r_pass_swap <= r_pass_swap | w_do_swap;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_pass  <= 2'd0;
          r_idx   <= 2'd0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: scoreboard bench for sort_sequencer.
// Expected results come from an independent model (counting sort for the
// data, inversion count for the swap total) and are queued at stimulus time.
module tb_sort_sequencer;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dataIn = 16'h0000;
  logic [15:0] dataOut;
  logic        busy;
  logic        done;
  logic [2:0]  swapCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  swaps;
    int          lat;
  } exp_t;

  exp_t sb[$];

  sort_sequencer dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .start     (start),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .busy      (busy),
    .done      (done),
    .swapCount (swapCount)
  );

  always #5 Clock = ~Clock;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d);
    exp_t r;
    int   cnt [16];
    int   ev  [4];
    int   pos;
    int   inv;
    logic [15:0] res;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = int'(d[4*i +: 4]);
      cnt[ev[i]]++;
    end
    inv = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (ev[i] > ev[j]) inv++;
    res = 16'h0000;
    pos = 0;
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < cnt[v]; c++) begin
        res[4*pos +: 4] = 4'(v);
        pos++;
      end
    r.data  = res;
    r.swaps = 3'(inv);
`ifdef SORT_SEQUENCER_EARLY_EXIT_EN
    begin
      int  cyc;
      bit  sw;
      int  t;
      cyc = 0;
      for (int p = 0; p < 3; p++) begin
        sw = 1'b0;
        for (int k = 0; k <= 2 - p; k++) begin
          cyc++;
          if (ev[k] > ev[k+1]) begin
            t = ev[k]; ev[k] = ev[k+1]; ev[k+1] = t; sw = 1'b1;
          end
        end
        if (!sw) break;
      end
      r.lat = cyc + 1;
    end
`else
    r.lat = 7;
`endif
    return r;
  endfunction

  // One sort transaction; optional second start while busy.
  task automatic run_sort(input logic [15:0] d, input bit collide, input string tag);
    exp_t e;
    int   cyc;
    int   dones;
    logic [15:0] held_data;
    logic [2:0]  held_swaps;
    @(negedge Clock);
    dataIn = d;
    start  = 1'b1;
    sb.push_back(model(d));
    @(negedge Clock);
    start = 1'b0;
    cyc   = 1;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && cyc < 20) begin
      if (collide && cyc == 2) begin
        dataIn = 16'hFFFF;
        start  = 1'b1;
      end else if (collide && cyc == 3) begin
        start = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_done"},    32'(done),      32'd1);
    chk({tag, "_latency"}, 32'(cyc),       32'(e.lat));
    chk({tag, "_data"},    32'(dataOut),   32'(e.data));
    chk({tag, "_swaps"},   32'(swapCount), 32'(e.swaps));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    $display("txn %s in=%h out=%h swaps=%0d latency=%0d", tag, d, dataOut, swapCount, cyc);
    held_data  = dataOut;
    held_swaps = swapCount;
    dataIn = ~d;
    dones  = 0;
    repeat (4) begin
      @(negedge Clock);
      if (done) dones++;
    end
    chk({tag, "_extra_done"}, 32'(dones), 32'd0);
    chk({tag, "_hold_data"},  32'(dataOut),   32'(held_data));
    chk({tag, "_hold_swaps"}, 32'(swapCount), 32'(held_swaps));
  endtask

  initial begin
    int dones;
    // Reset state
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_data",  32'(dataOut),   32'd0);
    chk("rst_swaps", 32'(swapCount), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    nReset = 1'b1;

    run_sort(16'h1234, 1'b0, "reversed");
    run_sort(16'h4321, 1'b0, "sorted");
    run_sort(16'h5A5A, 1'b0, "dups");
    run_sort(16'h1234, 1'b1, "collide");

    // Reset in the middle of a sort
    @(negedge Clock);
    dataIn = 16'h1234;
    start  = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b0;
    #1;
    chk("midrst_data",  32'(dataOut),   32'd0);
    chk("midrst_swaps", 32'(swapCount), 32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    chk("midrst_done",  32'(done),      32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    dones  = 0;
    repeat (10) begin
      @(negedge Clock);
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    $display("txn midrst in=1234 out=%h swaps=%0d", dataOut, swapCount);
    run_sort(16'h1234, 1'b0, "after_rst");

    run_sort(16'h0000, 1'b0, "zeros");
    run_sort(16'hFFFF, 1'b0, "ones");
    run_sort(16'h2143, 1'b0, "pairs");
    for (int n = 0; n < 6; n++) begin
      run_sort(16'($urandom), 1'b0, $sformatf("rand%0d", n));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
